// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter: ALU and load writebacks share one write port.
// Contested cycles alternate grants and are tallied in a saturating counter.
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  AluValid,
    input  logic [ADDR_WIDTH-1:0] AluRegister,
    input  logic [DATA_WIDTH-1:0] AluData,
    output logic                  AluReady,
    input  logic                  MemValid,
    input  logic [ADDR_WIDTH-1:0] MemRegister,
    input  logic [DATA_WIDTH-1:0] MemData,
    output logic                  MemReady,
    input  logic                  Freeze,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic                  RegWrite,
    output logic [ADDR_WIDTH-1:0] WriteRegister,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  ForwardHit1,
    output logic                  ForwardHit2,
    output logic [DATA_WIDTH-1:0] ForwardData,
    output logic [15:0]           ConflictCount
);

    logic                  priorityQ;      // 0: ALU wins next contest, 1: Mem wins
    logic                  regWriteQ;
    logic [ADDR_WIDTH-1:0] writeRegisterQ;
    logic [DATA_WIDTH-1:0] writeDataQ;
    logic [15:0]           conflictCountQ;

    logic                  open;
    logic                  contested;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] selRegister;
    logic [DATA_WIDTH-1:0] selData;

    always_comb begin
        open      = !Freeze && !Reset;
        contested = open && AluValid && MemValid;
        AluReady  = open && AluValid && (!MemValid || !priorityQ);
        MemReady  = open && MemValid && (!AluValid || priorityQ);
        accept    = AluReady || MemReady;
        if (MemReady) begin
            selRegister = MemRegister;
            selData     = MemData;
        end else begin
            selRegister = AluRegister;
            selData     = AluData;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            priorityQ      <= 1'b0;
            regWriteQ      <= 1'b0;
            writeRegisterQ <= '0;
            writeDataQ     <= '0;
            conflictCountQ <= '0;
        end else begin
            // Writes to index 0 are consumed but never reach the register file.
            regWriteQ <= accept && (selRegister != '0);
            if (accept) begin
                writeRegisterQ <= selRegister;
                writeDataQ     <= selData;
            end
            if (contested) begin
                priorityQ <= !priorityQ;
                if (conflictCountQ != 16'hFFFF) begin
                    conflictCountQ <= conflictCountQ + 16'd1;
                end
            end
        end
    end

    always_comb begin
        RegWrite      = regWriteQ;
        WriteRegister = writeRegisterQ;
        WriteData     = writeDataQ;
        ConflictCount = conflictCountQ;
        ForwardData   = writeDataQ;
        ForwardHit1   = !Reset && regWriteQ && (writeRegisterQ == ReadRegister1)
                        && (writeRegisterQ != '0);
        ForwardHit2   = !Reset && regWriteQ && (writeRegisterQ == ReadRegister2)
                        && (writeRegisterQ != '0);
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, reset/saturation sequences,
// and randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 6;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          AluValid, MemValid, Freeze;
    logic [AW-1:0] AluRegister, MemRegister, ReadRegister1, ReadRegister2;
    logic [DW-1:0] AluData, MemData;
    logic          AluReady, MemReady, RegWrite, ForwardHit1, ForwardHit2;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData, ForwardData;
    logic [15:0]   ConflictCount;

    int compared = 0;
    int mismatched = 0;

    always #5 Clock = ~Clock;

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clock(Clock), .Reset(Reset),
        .AluValid(AluValid), .AluRegister(AluRegister), .AluData(AluData), .AluReady(AluReady),
        .MemValid(MemValid), .MemRegister(MemRegister), .MemData(MemData), .MemReady(MemReady),
        .Freeze(Freeze), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ForwardHit1(ForwardHit1), .ForwardHit2(ForwardHit2), .ForwardData(ForwardData),
        .ConflictCount(ConflictCount)
    );

    typedef struct {
        logic          av;
        logic [AW-1:0] ar;
        logic [DW-1:0] ad;
        logic          mv;
        logic [AW-1:0] mr;
        logic [DW-1:0] md;
        logic          frz;
        logic [AW-1:0] rr1;
        logic [AW-1:0] rr2;
        logic          eAluRdy;
        logic          eMemRdy;
        logic          eHit1;
        logic          eHit2;
        logic          eRegWrite;
        logic [AW-1:0] eWriteReg;
        logic [DW-1:0] eWriteData;
        logic [15:0]   eCount;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                         input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                         input logic frz, input logic [AW-1:0] rr1, input logic [AW-1:0] rr2);
        AluValid = av; AluRegister = ar; AluData = ad;
        MemValid = mv; MemRegister = mr; MemData = md;
        Freeze = frz; ReadRegister1 = rr1; ReadRegister2 = rr2;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic doReset();
        idle();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #3 Reset = 1'b0;
        @(posedge Clock);
        #1;
    endtask

    // Behavioural model state for the random phase
    int            mNextMem;   // 1 when the load source owns the next contest
    int            mCount;
    logic          mRegWrite;
    logic [AW-1:0] mWriteReg;
    logic [DW-1:0] mWriteData;

    initial begin
        Reset = 1'b1;
        idle();
        #2;
        chk("reset_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("reset_writereg", {58'd0, WriteRegister}, 64'd0);
        chk("reset_writedata", WriteData, 64'd0);
        chk("reset_count", {48'd0, ConflictCount}, 64'd0);
        AluValid = 1'b1; MemValid = 1'b1;
        #1;
        chk("reset_aluready", {63'd0, AluReady}, 64'd0);
        chk("reset_memready", {63'd0, MemReady}, 64'd0);
        doReset();

        // av ar ad mv mr md frz rr1 rr2 | aluRdy memRdy hit1 hit2 | rw wr wd count
        vecs[0]  = '{1'b1, 6'd13, 64'd12345, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 6'd0,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd13, 64'd12345, 16'd0};
        vecs[1]  = '{1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0, 1'b0, 6'd13, 6'd0,
                     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd13, 64'd12345, 16'd0};
        vecs[2]  = '{1'b1, 6'd1, 64'd1, 1'b1, 6'd30, 64'h8000_0000_0000_0000, 1'b0, 6'd13, 6'd0,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 64'd1, 16'd1};
        vecs[3]  = '{1'b1, 6'd1, 64'd1, 1'b1, 6'd30, 64'h8000_0000_0000_0000, 1'b0, 6'd1, 6'd0,
                     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd30, 64'h8000_0000_0000_0000, 16'd2};
        vecs[4]  = '{1'b1, 6'd1, 64'd1, 1'b1, 6'd30, 64'h8000_0000_0000_0000, 1'b0, 6'd0, 6'd30,
                     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd1, 64'd1, 16'd3};
        vecs[5]  = '{1'b1, 6'd1, 64'd1, 1'b1, 6'd30, 64'h8000_0000_0000_0000, 1'b0, 6'd0, 6'd0,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd30, 64'h8000_0000_0000_0000, 16'd4};
        vecs[6]  = '{1'b0, 6'd0, 64'd0, 1'b1, 6'd0, 64'd14, 1'b0, 6'd0, 6'd0,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 64'd14, 16'd4};
        vecs[7]  = '{1'b1, 6'd5, 64'd77, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 6'd0,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 64'd77, 16'd4};
        vecs[8]  = '{1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0, 1'b0, 6'd5, 6'd9,
                     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd5, 64'd77, 16'd4};
        vecs[9]  = '{1'b1, 6'd7, 64'd70, 1'b1, 6'd8, 64'd80, 1'b1, 6'd5, 6'd9,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5, 64'd77, 16'd4};
        vecs[10] = '{1'b1, 6'd7, 64'd70, 1'b1, 6'd8, 64'd80, 1'b0, 6'd0, 6'd0,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd7, 64'd70, 16'd5};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr, vecs[i].md,
                  vecs[i].frz, vecs[i].rr1, vecs[i].rr2);
            #1;
            chk($sformatf("v%0d_aluready", i), {63'd0, AluReady}, {63'd0, vecs[i].eAluRdy});
            chk($sformatf("v%0d_memready", i), {63'd0, MemReady}, {63'd0, vecs[i].eMemRdy});
            chk($sformatf("v%0d_hit1", i), {63'd0, ForwardHit1}, {63'd0, vecs[i].eHit1});
            chk($sformatf("v%0d_hit2", i), {63'd0, ForwardHit2}, {63'd0, vecs[i].eHit2});
            @(posedge Clock);
            #1;
            chk($sformatf("v%0d_regwrite", i), {63'd0, RegWrite}, {63'd0, vecs[i].eRegWrite});
            chk($sformatf("v%0d_writereg", i), {58'd0, WriteRegister},
                {58'd0, vecs[i].eWriteReg});
            chk($sformatf("v%0d_writedata", i), WriteData, vecs[i].eWriteData);
            chk($sformatf("v%0d_fwddata", i), ForwardData, vecs[i].eWriteData);
            chk($sformatf("v%0d_count", i), {48'd0, ConflictCount}, {48'd0, vecs[i].eCount});
        end

        // Mid-cycle reset with a write in flight (RegWrite=1 for X7 here)
        idle();
        ReadRegister1 = 6'd7;
        #2 Reset = 1'b1;
        #1;
        chk("midreset_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("midreset_count", {48'd0, ConflictCount}, 64'd0);
        chk("midreset_writereg", {58'd0, WriteRegister}, 64'd0);
        chk("midreset_hit1", {63'd0, ForwardHit1}, 64'd0);
        #3 Reset = 1'b0;
        @(posedge Clock);
        #1;
        chk("postreset_regwrite", {63'd0, RegWrite}, 64'd0);
        drive(1'b1, 6'd2, 64'd22, 1'b1, 6'd3, 64'd33, 1'b0, 6'd0, 6'd0);
        #1;
        chk("postreset_prio_alu", {62'd0, AluReady, MemReady}, 64'd2);
        @(posedge Clock);
        #1;
        chk("postreset_write", {57'd0, RegWrite, WriteRegister}, {57'd0, 1'b1, 6'd2});

        // Randomized traffic against the behavioural model
        doReset();
        mNextMem = 0; mCount = 0; mRegWrite = 1'b0; mWriteReg = '0; mWriteData = '0;
        for (int n = 0; n < 3000; n++) begin
            logic          av, mv, frz, gA, gM;
            logic [AW-1:0] ar, mr, rr1, rr2;
            logic [DW-1:0] ad, md;
            av  = ($urandom_range(0, 3) != 0);
            mv  = ($urandom_range(0, 3) != 0);
            frz = ($urandom_range(0, 7) == 0);
            ar  = AW'($urandom_range(0, 7));
            mr  = AW'($urandom_range(0, 7));
            rr1 = AW'($urandom_range(0, 7));
            rr2 = AW'($urandom_range(0, 7));
            ad  = {$urandom, $urandom};
            md  = {$urandom, $urandom};
            drive(av, ar, ad, mv, mr, md, frz, rr1, rr2);
            gA = 1'b0; gM = 1'b0;
            if (!frz) begin
                if (av && mv) begin
                    if (mNextMem != 0) gM = 1'b1; else gA = 1'b1;
                end else begin
                    gA = av;
                    gM = mv;
                end
            end
            #1;
            chk("rnd_aluready", {63'd0, AluReady}, {63'd0, gA});
            chk("rnd_memready", {63'd0, MemReady}, {63'd0, gM});
            chk("rnd_hit1", {63'd0, ForwardHit1},
                {63'd0, mRegWrite && mWriteReg == rr1 && mWriteReg != 0});
            chk("rnd_hit2", {63'd0, ForwardHit2},
                {63'd0, mRegWrite && mWriteReg == rr2 && mWriteReg != 0});
            @(posedge Clock);
            #1;
            if (av && mv && !frz) begin
                mNextMem = 1 - mNextMem;
                if (mCount < 65535) mCount++;
            end
            mRegWrite = 1'b0;
            if (gA) begin mWriteReg = ar; mWriteData = ad; mRegWrite = (ar != 0); end
            if (gM) begin mWriteReg = mr; mWriteData = md; mRegWrite = (mr != 0); end
            chk("rnd_regwrite", {63'd0, RegWrite}, {63'd0, mRegWrite});
            chk("rnd_writereg", {58'd0, WriteRegister}, {58'd0, mWriteReg});
            chk("rnd_writedata", WriteData, mWriteData);
            chk("rnd_count", {48'd0, ConflictCount}, 64'(mCount));
        end

        // Saturation of the conflict counter
        doReset();
        drive(1'b1, 6'd1, 64'd1, 1'b1, 6'd2, 64'd2, 1'b0, 6'd0, 6'd0);
        repeat (65534) @(posedge Clock);
        #1;
        chk("sat_fffe", {48'd0, ConflictCount}, 64'h0000_0000_0000_FFFE);
        repeat (6) @(posedge Clock);
        #1;
        chk("sat_ffff", {48'd0, ConflictCount}, 64'h0000_0000_0000_FFFF);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64: register data width.
REQ-002 Parameter ADDR_WIDTH, default 6: register index width.
REQ-003 Clock  input  1: single clock; all state updates on its rising edge.
REQ-004 Reset  input  1: asynchronous, active-high reset.
REQ-005 AluValid  input  1: ALU writeback request.
REQ-006 AluRegister  input  ADDR_WIDTH: ALU destination index.
REQ-007 AluData  input  DATA_WIDTH: ALU result.
REQ-008 AluReady  output  1: ALU request accepted this cycle.
REQ-009 MemValid  input  1: load writeback request.
REQ-010 MemRegister  input  ADDR_WIDTH: load destination index.
REQ-011 MemData  input  DATA_WIDTH: load result.
REQ-012 MemReady  output  1: load request accepted this cycle.
REQ-013 Freeze  input  1: pipeline freeze; blocks new acceptances.
REQ-014 ReadRegister1, ReadRegister2  input  ADDR_WIDTH each: read indices currently presented to the register file.
REQ-015 RegWrite  output  1: write enable to register file.
REQ-016 WriteRegister  output  ADDR_WIDTH: write index to register file.
REQ-017 WriteData  output  DATA_WIDTH: write data to register file.
REQ-018 ForwardHit1, ForwardHit2  output  1 each: in-flight write matches the read index.
REQ-019 ForwardData  output  DATA_WIDTH: in-flight write data.
REQ-020 ConflictCount  output  16: saturating count of contested cycles.

Function
REQ-021 A request is accepted when Valid and Ready are both high in the same cycle; AluReady/MemReady are combinational and never high while the matching Valid is low.
REQ-022 Freeze=1 forces AluReady=MemReady=0.
REQ-023 One valid source, Freeze=0: that source's Ready=1.
REQ-024 Both valid, Freeze=0 (contested): exactly one Ready asserted, chosen by the Priority bit (0=ALU, 1=Mem); Priority toggles to the other source at the edge ending every contested cycle; uncontested acceptances leave Priority unchanged.
REQ-025 Accepted index/data load into the output stage at the accepting edge; RegWrite/WriteRegister/WriteData present them during the following cycle (latency 1), so the register file writes at the next edge.
REQ-026 Output stage reloads every cycle; with no acceptance, RegWrite=0 next cycle and WriteRegister/WriteData hold their last values.
REQ-027 Accepted write to index 0: consumed (Ready=1) but RegWrite stays 0; WriteRegister/WriteData still update.
REQ-028 ForwardHitN = RegWrite && WriteRegister==ReadRegisterN && WriteRegister!=0, combinational; ForwardData = WriteData.
REQ-029 ConflictCount increments by 1 at the edge ending each contested cycle, saturates at 16'hFFFF, never wraps.
REQ-030 Sustained throughput: one accepted write per cycle; no internal buffering beyond the output stage.

Reset
REQ-031 Reset high asynchronously forces RegWrite=0, WriteRegister=0, WriteData=0, Priority=0 (ALU), ConflictCount=0; Ready and ForwardHit outputs evaluate to 0 while Reset is high.
REQ-032 Reset during an in-flight write drops it; no RegWrite pulse follows reset release until a new acceptance.

Verification
REQ-033 ALU only: AluValid=1, AluRegister=13, AluData=12345 for one cycle -> AluReady=1 that cycle; next cycle RegWrite=1, WriteRegister=13, WriteData=12345; the cycle after, RegWrite=0.
REQ-034 Contention after reset: both valid for 4 cycles (ALU X1=1, Mem X30=1<<63) -> grants ALU, Mem, ALU, Mem; ConflictCount=4; each write appears on RegWrite one cycle after its grant.
REQ-035 X0 write: MemValid=1, MemRegister=0, MemData=14 -> MemReady=1; RegWrite remains 0; ForwardHit1=0 with ReadRegister1=0.
REQ-036 Forwarding: ALU write X5=77 accepted, ReadRegister1=5, ReadRegister2=9 next cycle -> ForwardHit1=1, ForwardHit2=0, ForwardData=77.
REQ-037 Freeze/reset: Freeze=1 with both valid -> no Ready, ConflictCount unchanged, RegWrite=0 next cycle; Reset pulsed mid-clock after an acceptance -> RegWrite drops to 0 immediately, Priority=ALU, ConflictCount=0.
REQ-038 Saturation: force 65540 contested cycles -> ConflictCount=16'hFFFF.
